// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU lane sequencer: op codes, FSM states and
// the bit positions of the {N,Z,V,C} flag nibble.
package alu_seq_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b111;
    localparam logic [2:0] ALU_DIV  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic v, input logic c);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_lane_sequencer.sv
// Time-multiplexes one scalar ALU over LANES operand lanes: accepts a vector
// request, feeds one lane per cycle to the ALU, and presents the result vector.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload while valid is high and ready is low;
// req_ready is high only in IDLE, rsp_valid is high only in RESP, and the
// response payload is frozen for the whole RESP interval.
module alu_lane_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [LANES*WIDTH-1:0] req_a,
    input  logic [LANES*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_sel,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_n,
    input  logic                   alu_z,
    input  logic                   alu_v,
    input  logic                   alu_c,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [LANES*WIDTH-1:0] rsp_data,
    output logic [LANES*4-1:0]     rsp_flags,
    output logic                   rsp_any_v,
    output logic                   rsp_all_z,
    output seq_state_e             dbg_state
);

    localparam int              CW   = $clog2(LANES);
    localparam logic [CW-1:0]   LAST = CW'(LANES - 1);

    seq_state_e       state;
    seq_state_e       state_nx;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q   [LANES];
    logic [WIDTH-1:0] b_q   [LANES];
    logic [WIDTH-1:0] res_q [LANES];
    logic [3:0]       flg_q [LANES];

    logic req_fire;
    logic rsp_fire;

    assign req_fire = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = ALU_PASS;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU operands come only from latched registers and the counter,
                // so live request inputs cannot disturb an operation in flight.
                alu_a   = a_q[cnt];
                alu_b   = b_q[cnt];
                alu_sel = op_q;
                if (cnt == LAST) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= ALU_PASS;
            for (int i = 0; i < LANES; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                cnt  <= '0;
                op_q <= req_op;
                for (int i = 0; i < LANES; i++) begin
                    a_q[i] <= req_a[i*WIDTH +: WIDTH];
                    b_q[i] <= req_b[i*WIDTH +: WIDTH];
                end
            end else if (state == ST_EXEC) begin
                res_q[cnt] <= alu_out;
                flg_q[cnt] <= pack_flags(alu_n, alu_z, alu_v, alu_c);
                // Wrap on the last lane so the counter never leaves 0..LANES-1.
                cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_pack
        assign rsp_data[i*WIDTH +: WIDTH] = res_q[i];
        assign rsp_flags[i*4 +: 4]        = flg_q[i];
    end

    always_comb begin
        rsp_any_v = 1'b0;
        rsp_all_z = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            rsp_any_v = rsp_any_v | flg_q[i][FLAG_V];
            rsp_all_z = rsp_all_z & flg_q[i][FLAG_Z];
        end
    end

    assign dbg_state = state;

    logic unused_ok;
    assign unused_ok = rsp_fire;

endmodule

// File: doc/alu_lane_sequencer.md
ALU_LANE_SEQUENCER -- requirements
Module: alu_lane_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 18, lane data width matching the scalar ALU.
REQ-002 SHALL have parameter LANES, default 4, number of vector lanes, range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  vector operation offered.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept.
REQ-007 SHALL have port req_op  input  3  ALU select: 100 add, 101 sub, 111 mul, 110 div, others pass A.
REQ-008 SHALL have ports req_a / req_b  input  LANES*WIDTH  operand vectors; lane i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have ports alu_a / alu_b  output  WIDTH  operands to the scalar ALU.
REQ-010 SHALL have port alu_sel  output  3  select to the ALU.
REQ-011 SHALL have ports alu_out  input  WIDTH and alu_n/alu_z/alu_v/alu_c  input  1 each  combinational ALU result and flags.
REQ-012 SHALL have port rsp_valid  output  1  result vector available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-014 SHALL have port rsp_data  output  LANES*WIDTH  per-lane results, same lane packing as req_a.
REQ-015 SHALL have port rsp_flags  output  LANES*4  per-lane {N,Z,V,C}, lane i at [i*4 +: 4].
REQ-016 SHALL have ports rsp_any_v / rsp_all_z  output  1 each  OR of lane V flags, AND of lane Z flags.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-018 req_ready SHALL equal 1 only in IDLE; accept on clk edge with req_valid&&req_ready; latch req_op, req_a, req_b; lane counter := 0; go EXEC.
REQ-019 In EXEC, alu_a/alu_b SHALL be the latched lane[counter] operands and alu_sel the latched op, driven from registers and the counter only.
REQ-020 Each EXEC cycle SHALL capture alu_out and flags into lane[counter] of rsp_data/rsp_flags, then increment the counter.
REQ-021 Capture of lane LANES-1 SHALL move the FSM to RESP; rsp_valid SHALL rise exactly LANES cycles after the accepting edge.
REQ-022 In RESP, rsp_valid=1; rsp_data, rsp_flags, rsp_any_v, rsp_all_z SHALL hold stable until rsp_valid&&rsp_ready.
REQ-023 The response handshake edge SHALL return the FSM to IDLE; the next request SHALL be acceptable on the following edge.
REQ-024 Outside EXEC, alu_a=0, alu_b=0, alu_sel=000.
REQ-025 rsp_any_v/rsp_all_z SHALL be computed from the registered rsp_flags, valid whenever rsp_valid=1.
REQ-026 The lane counter SHALL be $clog2(LANES) bits and SHALL never exceed LANES-1.
REQ-027 req_valid while not in IDLE SHALL be ignored; no input changes SHALL affect an in-flight operation.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counter 0, rsp_data 0, rsp_flags 0, rsp_valid 0, rsp_any_v 0, rsp_all_z 0 and req_ready 1 (the latter two once rst_n is released).
REQ-029 Reset mid-EXEC or mid-RESP SHALL discard the operation; no rsp_valid SHALL follow for it.

Structure
REQ-030 Shared package alu_seq_pkg SHALL hold op-code constants (ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_PASS), the FSM state enum and flag bit indices (N=3, Z=2, V=1, C=0).
REQ-031 No sub-module SHALL be instantiated; the scalar ALU is instantiated beside this block by its parent.

Verification (WIDTH=18, LANES=4, real ALU attached)
REQ-032 Add, A={1,2,3,0x1FFFF}, B={1,1,1,1} -> rsp_data={2,3,4,0x20000}; lane3 N=1, V=1; rsp_any_v=1; rsp_valid 4 cycles after accept.
REQ-033 Sub, A=B={5,5,5,5} -> rsp_data all 0, every Z=1, rsp_all_z=1, rsp_any_v=0.
REQ-034 Any op, rsp_ready held 0 for 3 cycles in RESP -> rsp_valid, rsp_data stable, req_ready=0; rsp_ready=1 -> IDLE next edge.
REQ-035 rst_n pulsed low while counter=2 -> outputs zero immediately, req_ready=1 after release, no rsp_valid for that request.
REQ-036 Back-to-back: second request held valid during first -> accepted on the edge after the first response handshake, never earlier.
REQ-037 Op 000, A={7,0,9,1} -> rsp_data={7,0,9,1}; lane1 Z=1; all V=C=0.
